// File: rtl/source_switch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// source_switch_ctrl_pkg
// Shared definitions for the source switch controller: channel encodings of
// the data source selector, the controller state enumeration and a channel
// validity helper.
// ----------------------------------------------------------------------------
package source_switch_ctrl_pkg;

    localparam logic [2:0] CH_STOP  = 3'd0;
    localparam logic [2:0] CH_FIXED = 3'd1;
    localparam logic [2:0] CH_RAM   = 3'd2;
    localparam logic [2:0] CH_SSD   = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        RUN
    } state_e;

    // Channels 4..7 have no source behind them.
    function automatic logic ch_valid(input logic [2:0] ch);
        return (ch == CH_STOP) || (ch == CH_FIXED) || (ch == CH_RAM) || (ch == CH_SSD);
    endfunction

endpackage

// File: rtl/source_switch_ctrl_switch_pulse_gen.sv
// ----------------------------------------------------------------------------
// source_switch_ctrl_switch_pulse_gen
// Generates one selector load sequence: one setup cycle with update_flag low
// (channel_choose already stable), update_flag high for PULSE_LEN cycles, then
// a SETTLE_CYC countdown covering the selector's synchronizer and output
// register. Used for both start and stop switches.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   i_start          begin a sequence (only while idle)
//   o_update_flag    registered load pulse to the selector
//   o_pulse_end      last cycle of the high phase
//   o_live           last settle cycle; the new source is live after this edge
// ----------------------------------------------------------------------------
module source_switch_ctrl_switch_pulse_gen #(
    parameter int unsigned PULSE_LEN  = 4,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_start,
    output logic o_update_flag,
    output logic o_pulse_end,
    output logic o_live
);

    localparam int unsigned MaxLen = (PULSE_LEN > SETTLE_CYC) ? PULSE_LEN : SETTLE_CYC;
    localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

    typedef enum logic [1:0] {
        PG_IDLE,
        PG_ARM,
        PG_HIGH,
        PG_SETTLE
    } pg_state_e;

    pg_state_e       r_phase, w_phase_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic            r_flag, w_flag_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= PG_IDLE;
            r_cnt   <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flag  <= w_flag_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_flag_nxt  = r_flag;
        unique case (r_phase)
            PG_IDLE: begin
                if (i_start) begin
                    w_phase_nxt = PG_ARM;
                end
            end
            PG_ARM: begin
                w_phase_nxt = PG_HIGH;
                w_flag_nxt  = 1'b1;
                w_cnt_nxt   = CntW'(PULSE_LEN - 1);
            end
            PG_HIGH: begin
                if (r_cnt == '0) begin
                    // Falling edge of update_flag loads the selection.
                    w_phase_nxt = PG_SETTLE;
                    w_flag_nxt  = 1'b0;
                    w_cnt_nxt   = CntW'(SETTLE_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            PG_SETTLE: begin
                if (r_cnt == '0) begin
                    w_phase_nxt = PG_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
        endcase
    end

    assign o_update_flag = r_flag;
    assign o_pulse_end   = (r_phase == PG_HIGH) && (r_cnt == '0);
    assign o_live        = (r_phase == PG_SETTLE) && (r_cnt == '0);

endmodule

// File: rtl/source_switch_ctrl.sv
// ----------------------------------------------------------------------------
// source_switch_ctrl
// Sequencer for the data source selector. Takes "play channel N for W words"
// commands, switches the selector via channel_choose/update_flag, counts
// dat_wren words while running and switches back to the stop channel on
// burst end, watchdog timeout or preemption by a new command.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready   command handshake (ready in IDLE and RUN)
//   i_cmd_channel, i_cmd_words  target channel (4..7 invalid), burst length
//   i_dat_wren                selector output write strobe (monitor only)
//   o_channel_choose, o_update_flag  selector select interface
//   o_busy, o_active_channel, o_word_count  status
//   o_done, o_timeout, o_err_bad_channel    one-cycle event pulses
// ----------------------------------------------------------------------------
module source_switch_ctrl
    import source_switch_ctrl_pkg::*;
#(
    parameter int unsigned PULSE_LEN   = 4,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_cmd_channel,
    input  logic [15:0] i_cmd_words,
    input  logic        i_dat_wren,
    output logic [2:0]  o_channel_choose,
    output logic        o_update_flag,
    output logic        o_busy,
    output logic [2:0]  o_active_channel,
    output logic [15:0] o_word_count,
    output logic        o_done,
    output logic        o_timeout,
    output logic        o_err_bad_channel
);

    localparam bit WdEn = (TIMEOUT_CYC != 0);

    state_e      r_state, w_state_nxt;
    logic [2:0]  r_target, w_target_nxt;
    logic [15:0] r_words, w_words_nxt;
    logic [2:0]  r_active;
    logic [15:0] r_count;
    logic [15:0] r_idle;
    logic        r_done, r_timeout, r_err;

    logic        w_cmd_acc, w_cmd_ok, w_cmd_bad;
    logic        w_word, w_burst_end, w_wd_fire;
    logic [15:0] w_count_inc;
    logic        w_start, w_run_entry, w_done_nxt, w_timeout_nxt;
    logic        w_pulse_end, w_live;

    assign o_cmd_ready = (r_state == IDLE) || (r_state == RUN);
    assign w_cmd_acc   = i_cmd_valid && o_cmd_ready;
    assign w_cmd_ok    = w_cmd_acc && ch_valid(i_cmd_channel);
    assign w_cmd_bad   = w_cmd_acc && !ch_valid(i_cmd_channel);

    // Words arriving outside RUN belong to a source being switched away from.
    assign w_word      = (r_state == RUN) && i_dat_wren;
    assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
    assign w_burst_end = w_word && (r_words != 16'd0) && (w_count_inc == r_words);
    assign w_wd_fire   = WdEn && (r_state == RUN) && !i_dat_wren
                         && (r_idle == 16'(TIMEOUT_CYC - 1));

    source_switch_ctrl_switch_pulse_gen #(
        .PULSE_LEN  (PULSE_LEN),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_pulse_gen (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (w_start),
        .o_update_flag (o_update_flag),
        .o_pulse_end   (w_pulse_end),
        .o_live        (w_live)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_target_nxt  = r_target;
        w_words_nxt   = r_words;
        w_start       = 1'b0;
        w_run_entry   = 1'b0;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cmd_ok) begin
                    w_state_nxt  = PULSE;
                    w_target_nxt = i_cmd_channel;
                    w_words_nxt  = i_cmd_words;
                    w_start      = 1'b1;
                end
            end
            PULSE: begin
                if (w_pulse_end) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (w_live) begin
                    if (r_target == CH_STOP) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                        w_run_entry = 1'b1;
                    end
                end
            end
            RUN: begin
                // Preempt beats burst end beats watchdog.
                if (w_cmd_ok) begin
                    w_state_nxt  = PULSE;
                    w_target_nxt = i_cmd_channel;
                    w_words_nxt  = i_cmd_words;
                    w_start      = 1'b1;
                end else if (w_burst_end) begin
                    w_state_nxt  = PULSE;
                    w_target_nxt = CH_STOP;
                    w_start      = 1'b1;
                end else if (w_wd_fire) begin
                    w_state_nxt   = PULSE;
                    w_target_nxt  = CH_STOP;
                    w_start       = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_target  <= CH_STOP;
            r_words   <= 16'd0;
            r_active  <= CH_STOP;
            r_count   <= 16'd0;
            r_idle    <= 16'd0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_target  <= w_target_nxt;
            r_words   <= w_words_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_err     <= w_cmd_bad;

            if (w_run_entry) begin
                r_active <= r_target;
            end else if ((r_state == RUN) && (w_state_nxt != RUN)) begin
                r_active <= CH_STOP;
            end

            if (w_run_entry) begin
                r_count <= 16'd0;
            end else if (w_word) begin
                r_count <= w_count_inc;
            end

            if (w_run_entry || w_word) begin
                r_idle <= 16'd0;
            end else if (WdEn && (r_state == RUN)) begin
                r_idle <= r_idle + 16'd1;
            end
        end
    end

    assign o_channel_choose  = r_target;
    assign o_busy            = (r_state != IDLE);
    assign o_active_channel  = r_active;
    assign o_word_count      = r_count;
    assign o_done            = r_done;
    assign o_timeout         = r_timeout;
    assign o_err_bad_channel = r_err;

endmodule

// File: tb/tb_source_switch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_source_switch_ctrl
// Self-checking bench for source_switch_ctrl. Expected behaviour is derived
// from transaction-level rules: switch timing from accept, word counts from
// the number of strobes fed while running, and event-pulse tallies.
// ----------------------------------------------------------------------------
module tb_source_switch_ctrl;

    localparam int P = 4;
    localparam int S = 4;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_channel = 3'd0;
    logic [15:0] cmd_words = 16'd0;
    logic        dat_wren = 1'b0;
    logic [2:0]  channel_choose;
    logic        update_flag;
    logic        busy;
    logic [2:0]  active_channel;
    logic [15:0] word_count;
    logic        done;
    logic        timeout;
    logic        err_bad_channel;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_to     = 0;
    int n_err    = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    source_switch_ctrl #(
        .PULSE_LEN   (P),
        .SETTLE_CYC  (S),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_cmd_valid       (cmd_valid),
        .o_cmd_ready       (cmd_ready),
        .i_cmd_channel     (cmd_channel),
        .i_cmd_words       (cmd_words),
        .i_dat_wren        (dat_wren),
        .o_channel_choose  (channel_choose),
        .o_update_flag     (update_flag),
        .o_busy            (busy),
        .o_active_channel  (active_channel),
        .o_word_count      (word_count),
        .o_done            (done),
        .o_timeout         (timeout),
        .o_err_bad_channel (err_bad_channel)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; tally event pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (done) n_done++;
        if (timeout) n_to++;
        if (err_bad_channel) n_err++;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_chan"}, int'(channel_choose), 0);
        check_eq({tag, "_flag"}, int'(update_flag), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_active"}, int'(active_channel), 0);
        check_eq({tag, "_wcount"}, int'(word_count), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_timeout"}, int'(timeout), 0);
        check_eq({tag, "_err"}, int'(err_bad_channel), 0);
        check_eq({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    task automatic send_cmd(input int ch, input int words);
        cmd_valid   = 1'b1;
        cmd_channel = 3'(ch);
        cmd_words   = 16'(words);
        check_eq("cmd_ready_at_send", int'(cmd_ready), 1);
        tick();
        cmd_valid   = 1'b0;
        cmd_channel = 3'd0;
        cmd_words   = 16'd0;
    endtask

    // Called just after the edge that decided a switch to ch. Pulse high on
    // cycles 1..P, selection stable, switch complete at cycle 1+P+S.
    task automatic expect_switch(input int ch, input bit noisy);
        int hi = 0;
        int first = -1;
        int last = -1;
        int chg = 0;
        int rdy = 0;
        int fin = -1;
        check_eq("sw_chan_at_accept", int'(channel_choose), ch);
        for (int k = 1; k <= 1 + P + S; k++) begin
            if (noisy) dat_wren = 1'($urandom_range(0, 1));
            tick();
            if (update_flag) begin
                hi++;
                if (first < 0) first = k;
                last = k;
            end
            if (int'(channel_choose) != ch) chg++;
            if (k < 1 + P + S && cmd_ready) rdy++;
            if (fin < 0 && ((ch != 0) ? (int'(active_channel) == ch) : !busy)) fin = k;
        end
        dat_wren = 1'b0;
        check_eq("sw_flag_cycles", hi, P);
        check_eq("sw_flag_first", first, 1);
        check_eq("sw_flag_last", last, P);
        check_eq("sw_chan_changes", chg, 0);
        check_eq("sw_ready_high", rdy, 0);
        check_eq("sw_latency", fin, 1 + P + S);
        if (ch != 0) begin
            check_eq("run_busy", int'(busy), 1);
            check_eq("run_ready", int'(cmd_ready), 1);
            check_eq("run_wcount_clear", int'(word_count), 0);
            check_eq("run_no_done", int'(done), 0);
        end else begin
            check_eq("stop_done", int'(done), 1);
            check_eq("stop_active", int'(active_channel), 0);
        end
    endtask

    task automatic feed_words(input int n);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(0, 4));
            repeat (gap) tick();
            dat_wren = 1'b1;
            tick();
            dat_wren = 1'b0;
            exp_count++;
            check_eq("word_count", int'(word_count), exp_count);
        end
    endtask

    // Called just after the edge carrying the final burst word.
    task automatic finish_stop();
        int d0;
        check_eq("end_chan", int'(channel_choose), 0);
        check_eq("end_active", int'(active_channel), 0);
        check_eq("end_busy", int'(busy), 1);
        check_eq("end_ready", int'(cmd_ready), 0);
        d0 = n_done;
        expect_switch(0, 1'b1);
        check_eq("end_done_count", n_done - d0, 1);
        tick();
        check_eq("end_done_oneshot", int'(done), 0);
    endtask

    task automatic burst(input int ch, input int words);
        send_cmd(ch, words);
        expect_switch(ch, 1'b1);
        exp_count = 0;
        feed_words(words);
        finish_stop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int d0;
        int e0;
        int t0;
        int k;
        int ch;
        int w;
        int m;
        int ch2;
        int w2;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;
        tick();

        // Basic finite burst
        burst(1, 8);

        // Continuous burst, invalid command while running, then preempt
        send_cmd(3, 0);
        expect_switch(3, 1'b1);
        exp_count = 0;
        feed_words(1000);
        check_eq("cont_wcount", int'(word_count), 1000);
        check_eq("cont_active", int'(active_channel), 3);
        e0 = n_err;
        send_cmd(6, 9);
        check_eq("run_bad_err", int'(err_bad_channel), 1);
        check_eq("run_bad_active", int'(active_channel), 3);
        check_eq("run_bad_chan", int'(channel_choose), 3);
        check_eq("run_bad_wcount", int'(word_count), 1000);
        d0 = n_done;
        send_cmd(2, 6);
        check_eq("preempt_active", int'(active_channel), 0);
        expect_switch(2, 1'b1);
        check_eq("preempt_no_done", n_done - d0, 0);
        check_eq("run_bad_err_count", n_err - e0, 1);
        exp_count = 0;
        feed_words(6);
        finish_stop();

        // Invalid channel in IDLE
        send_cmd(5, 3);
        check_eq("idle_bad_err", int'(err_bad_channel), 1);
        check_eq("idle_bad_busy", int'(busy), 0);
        check_eq("idle_bad_chan", int'(channel_choose), 0);
        check_eq("idle_bad_wcount", int'(word_count), exp_count);
        tick();
        check_eq("idle_bad_err_oneshot", int'(err_bad_channel), 0);
        check_eq("idle_bad_busy2", int'(busy), 0);

        // Watchdog timeout
        send_cmd(2, 4);
        expect_switch(2, 1'b0);
        exp_count = 0;
        t0 = n_to;
        k = 0;
        while (!timeout && k < 40) begin
            tick();
            k++;
        end
        check_eq("timeout_latency", k, T);
        check_eq("timeout_chan", int'(channel_choose), 0);
        check_eq("timeout_active", int'(active_channel), 0);
        d0 = n_done;
        expect_switch(0, 1'b0);
        check_eq("timeout_count", n_to - t0, 1);
        check_eq("timeout_done", n_done - d0, 1);

        // Command on the same cycle as the final burst word
        send_cmd(1, 3);
        expect_switch(1, 1'b1);
        exp_count = 0;
        feed_words(2);
        d0 = n_done;
        dat_wren    = 1'b1;
        cmd_valid   = 1'b1;
        cmd_channel = 3'd3;
        cmd_words   = 16'd5;
        check_eq("coll_ready", int'(cmd_ready), 1);
        tick();
        dat_wren  = 1'b0;
        cmd_valid = 1'b0;
        check_eq("coll_chan", int'(channel_choose), 3);
        check_eq("coll_busy", int'(busy), 1);
        expect_switch(3, 1'b0);
        check_eq("coll_no_done", n_done - d0, 0);
        exp_count = 0;
        feed_words(5);
        finish_stop();

        // Reset during PULSE
        send_cmd(1, 2);
        tick();
        check_eq("rst_pre_flag", int'(update_flag), 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        tick();
        check_reset_vals("rst_edge");
        reset_n = 1'b1;
        exp_count = 0;
        tick();
        burst(1, 2);

        // Randomized commands
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                e0 = n_err;
                send_cmd(int'($urandom_range(4, 7)), int'($urandom_range(0, 50)));
                check_eq("rnd_bad_busy", int'(busy), 0);
                check_eq("rnd_bad_chan", int'(channel_choose), 0);
                tick();
                check_eq("rnd_bad_err", n_err - e0, 1);
            end
            ch = int'($urandom_range(0, 3));
            w  = int'($urandom_range(1, 30));
            send_cmd(ch, w);
            if (ch == 0) begin
                d0 = n_done;
                expect_switch(0, 1'b1);
                check_eq("rnd_stop_done", n_done - d0, 1);
                tick();
            end else begin
                expect_switch(ch, 1'b1);
                exp_count = 0;
                if ($urandom_range(0, 3) == 0) begin
                    m = int'($urandom_range(0, w - 1));
                    feed_words(m);
                    d0  = n_done;
                    ch2 = int'($urandom_range(1, 3));
                    w2  = int'($urandom_range(1, 30));
                    send_cmd(ch2, w2);
                    expect_switch(ch2, 1'b1);
                    check_eq("rnd_preempt_no_done", n_done - d0, 0);
                    exp_count = 0;
                    w = w2;
                end
                feed_words(w);
                finish_stop();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/source_switch_ctrl.md
Name: source_switch_ctrl

Overview:
- Sequencer that drives the channel-select interface (channel_choose, update_flag) of the data source selector.
- Accepts host commands of the form "play channel N for W words". Generates the update_flag pulse whose falling edge loads the selection, then waits for the selector's synchronizer and output-register latency.
- Counts dat_wren words from the selected source. Returns the selector to the stop channel on burst end, on timeout, or when preempted by a new command.

Parameters:
- PULSE_LEN, 4, cycles update_flag is held high per switch (≥2).
- SETTLE_CYC, 4, cycles after the update_flag falling edge before the new source is considered live (≥3: 2-stage sync + output register).
- TIMEOUT_CYC, 65535, max idle cycles without dat_wren while running; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted on the cycle where cmd_valid & cmd_ready
- cmd_channel  in  3  0=stop, 1=fixed, 2=ram, 3=ssd; 4..7 invalid
- cmd_words  in  16  burst length in words; 0 = continuous until the next command
- dat_wren  in  1  write strobe at the selector output (monitor)
- channel_choose  out  3  selection presented to the selector
- update_flag  out  1  selection load pulse; the falling edge loads the selection
- busy  out  1  high in any state other than IDLE
- active_channel  out  3  channel currently live (valid in RUN, else 0)
- word_count  out  16  words counted in the current burst
- done  out  1  one-cycle pulse when the block returns to IDLE
- timeout  out  1  one-cycle pulse on watchdog expiry
- err_bad_channel  out  1  one-cycle pulse when an invalid channel is accepted

Behaviour:
- Reset values:
  - Outputs: channel_choose=0, update_flag=0, busy=0, active_channel=0, word_count=0, done=0, timeout=0, err_bad_channel=0, cmd_ready=1.
  - Internal: state=IDLE, all counters 0.
- Reset mid-operation aborts everything immediately. channel_choose returns to 0, but no update_flag edge is generated; the selector resets to stop independently.
- cmd_ready = 1 in IDLE and RUN, 0 in PULSE and SETTLE.
- Invalid channel (4..7) accepted: err_bad_channel pulses the next cycle; state, channel_choose and counters are unchanged.
- States:
  - IDLE: on a valid accepted command, latch channel and words, set channel_choose=cmd_channel, go to PULSE.
  - PULSE:
    - update_flag=1 for exactly PULSE_LEN cycles; channel_choose stable throughout.
    - Then update_flag=0 and go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles, then:
    - If the target channel is 0: go to IDLE, pulse done.
    - Otherwise: go to RUN, clear word_count, set active_channel=target.
  - RUN:
    - Each dat_wren increments word_count, saturating at 0xFFFF.
    - If latched words≠0 and the increment makes word_count==words: target=0, go to PULSE (stop switch).
    - If watchdog is enabled and there has been no dat_wren for TIMEOUT_CYC consecutive cycles: timeout pulse, target=0, go to PULSE.
    - Valid command accepted in RUN (preempt): latch the new channel and words, go to PULSE. No done pulse for the aborted burst.
    - Priority on the same cycle: accepted command > burst-end > timeout.
- active_channel is forced to 0 on leaving RUN.
- dat_wren outside RUN is ignored; late words from the previous source are not counted.
- The watchdog counter resets on every dat_wren and on RUN entry.
- Latency from command accept to RUN = 1 + PULSE_LEN + SETTLE_CYC cycles.

Decomposition:
- Shared package holds:
  - channel encodings: CH_STOP=0, CH_FIXED=1, CH_RAM=2, CH_SSD=3;
  - the FSM state enumeration: IDLE, PULSE, SETTLE, RUN.
- One natural sub-module: switch_pulse_gen. It generates the update_flag pulse plus settle countdown and returns a "live" strobe; it is reused for both start and stop switches.

Test Plan:
- Reset, then cmd ch=1 words=8, feed 8 dat_wren in RUN -> update_flag high 4 cycles; RUN reached 9 cycles after accept; stop pulse after the 8th word; done pulse; channel_choose=0.
- cmd ch=3 words=0, feed 1000 words -> stays in RUN; word_count=1000; no done. Then cmd ch=2 preempt -> new pulse, channel_choose=2, no done.
- cmd ch=5 in IDLE -> err_bad_channel pulse; busy stays 0; channel_choose stays 0.
- TIMEOUT_CYC=16, cmd ch=2 words=4, feed no words -> timeout pulse exactly 16 cycles after RUN entry, stop switch, done.
- Command arriving on the same cycle as the final burst word -> command wins; no stop switch, no done; new channel selected.
- Assert reset_n during PULSE -> all outputs at reset values next edge. After release, a cmd ch=1 completes normally.
